// File: rtl/leb128_pkg.sv
// Shared definitions for the LEB128 encoder: operand type codes, maximum
// encoding lengths, FSM state encoding and the operand capture helper.
package leb128_pkg;

  // Operand type codes (same values as the CPU's type field).
  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  // Longest legal encodings: ceil(32/7) and ceil(64/7) bytes.
  localparam logic [3:0] LEB128_MAX_I32 = 4'd5;
  localparam logic [3:0] LEB128_MAX_I64 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Widen the request value to 64 bits: i32 is sign- or zero-extended
  // from bit 31 so that the shift register always holds the full value.
  function automatic logic [63:0] capture_value(input logic [63:0] value,
                                                input logic        is_i64,
                                                input logic        is_signed);
    if (is_i64) begin
      return value;
    end
    return {{32{is_signed & value[31]}}, value[31:0]};
  endfunction

endpackage

// File: rtl/leb128_last_detect.sv
// Combinational final-byte detector for the LEB128 encoder.
// Minimal form: unsigned ends when nothing is left above the 7-bit payload;
// signed ends when the remaining bits, including payload bit 6, are all
// copies of the sign (so the decoder's sign extension restores them).
// Padded form ends only at the maximum byte count.
module leb128_last_detect (
  input  logic [63:0] rem,
  input  logic        is_signed,
  input  logic [3:0]  count,
  input  logic [3:0]  max_len,
  input  logic        pad,
  output logic        last
);

  logic minimal;
  logic at_max;

  // Evaluate the minimal-length end condition and the length cap.
  always_comb begin
    // rem[63:6] all-zero / all-one is the same test as
    // (rem>>>7)==0 && rem[6]==0  /  (rem>>>7)==-1 && rem[6]==1.
    minimal = is_signed ? ((rem[63:6] == '0) || (rem[63:6] == '1))
                        : (rem[63:7] == '0);
    at_max  = (count == max_len);
    last    = pad ? at_max : (minimal || at_max);
  end

endmodule

// File: rtl/leb128_encoder.sv
// LEB128 encoder: accepts one i32/i64 per transaction and emits its
// SLEB128/ULEB128 bytes one per cycle with valid/ready flow control.
// Float types (and i64 when USE_64B=0) are rejected with an out_error pulse.
// Optional feature macro: LEB128_PAD_EN (in_pad=1 pads to maximum length).
module leb128_encoder
  import leb128_pkg::*;
#(
  parameter int USE_64B = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic [1:0]  in_type,
  input  logic        in_signed,
  input  logic        in_pad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [3:0]  out_count,
  output logic        out_error
);

  localparam bit ALLOW_I64 = (USE_64B != 0);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] rem;
  logic [63:0] rem_shr;
  logic        rem_signed;
  logic [3:0]  count;
  logic [3:0]  max_len;
  logic        pad;
  logic        pad_req;
  logic        last;
  logic        accept;
  logic        req_ok;
  logic        req_is_i64;

`ifdef LEB128_PAD_EN
  assign pad_req = in_pad;
`else
  logic unused_pad;
  assign pad_req    = 1'b0;
  assign unused_pad = in_pad;
`endif

  assign req_is_i64 = (in_type == TYPE_I64);
  assign req_ok     = (in_type == TYPE_I32) || (req_is_i64 && ALLOW_I64);
  assign accept     = in_valid && in_ready;

  // Shift out one 7-bit group; sign fill only for the signed form.
  assign rem_shr = {{7{rem_signed & rem[63]}}, rem[63:7]};

  leb128_last_detect u_last_detect (
    .rem       (rem),
    .is_signed (rem_signed),
    .count     (count),
    .max_len   (max_len),
    .pad       (pad),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = req_ok ? ST_EMIT : ST_ERR;
      ST_EMIT: if (out_ready && last) state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-byte shift and byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem        <= '0;
      rem_signed <= 1'b0;
      count      <= '0;
      max_len    <= '0;
      pad        <= 1'b0;
    end else if (accept && req_ok) begin
      rem        <= capture_value(in_value, req_is_i64, in_signed);
      rem_signed <= in_signed;
      count      <= 4'd1;
      max_len    <= req_is_i64 ? LEB128_MAX_I64 : LEB128_MAX_I32;
      pad        <= pad_req;
    end else if (out_valid && out_ready) begin
      if (last) begin
        count <= '0;
      end else begin
        rem   <= rem_shr;
        count <= count + 4'd1;
      end
    end
  end

  // Handshake and byte outputs; all held while the consumer stalls
  // because rem and count only move on a handshake.
  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_EMIT);
  assign out_error = (state == ST_ERR);
  assign out_last  = out_valid && last;
  assign out_data  = out_valid ? {~last, rem[6:0]} : 8'h00;
  assign out_count = count;

endmodule

// File: tb/tb_leb128_encoder.sv
// Self-checking bench for leb128_encoder: directed vectors from the
// encoding examples plus randomized requests checked against a
// behavioural LEB128 model. Honors LEB128_PAD_EN when defined.
module tb_leb128_encoder;
  import leb128_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_value = '0;
  logic [1:0]  in_type = TYPE_I32;
  logic        in_signed = 1'b0;
  logic        in_pad = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_count;
  logic        out_error;

  int vectors = 0;
  int miscompares = 0;

  leb128_encoder #(.USE_64B(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_type   (in_type),
    .in_signed (in_signed),
    .in_pad    (in_pad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_count (out_count),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LEB128 encoder written from the format definition.
  function automatic bq_t encode(input logic [1:0] t, input logic [63:0] v,
                                 input logic s, input logic p);
    bq_t        q;
    longint     x;
    logic [6:0] b;
    bit         done;
    int         maxn;
    maxn = (t == TYPE_I64) ? 10 : 5;
    if (t == TYPE_I64) x = longint'(v);
    else if (s)        x = longint'(signed'(v[31:0]));
    else               x = longint'({32'b0, v[31:0]});
    do begin
      b = x[6:0];
      x = s ? (x >>> 7) : (x >> 7);
      if (p) done = (q.size() + 1 == maxn);
      else if (s) done = ((x == 0) && !b[6]) || ((x == -1) && b[6]);
      else done = (x == 0);
      q.push_back({~done, b});
    end while (!done);
    return q;
  endfunction

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] t, input logic [63:0] v,
                      input logic s, input logic p);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid  = 1'b1;
    in_type   = t;
    in_value  = v;
    in_signed = s;
    in_pad    = p;
    @(negedge clk);
    in_valid  = 1'b0;
    in_value  = {$urandom, $urandom};
    in_type   = 2'($urandom_range(0, 3));
    in_signed = 1'($urandom_range(0, 1));
    in_pad    = 1'($urandom_range(0, 1));
  endtask

  // Consume the expected bytes back-to-back, optionally stalling on one byte.
  task automatic recv(input string name, input bq_t exp,
                      input int stall_at, input int stall_len);
    int n = exp.size();
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          chk($sformatf("%s hold_data[%0d]", name, i), out_data, exp[i]);
          chk($sformatf("%s hold_count[%0d]", name, i), out_count, i + 1);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s valid[%0d]", name, i), out_valid, 1);
      chk($sformatf("%s data[%0d]", name, i), out_data, exp[i]);
      chk($sformatf("%s last[%0d]", name, i), out_last, (i == n - 1));
      chk($sformatf("%s count[%0d]", name, i), out_count, i + 1);
      @(negedge clk);
    end
    chk($sformatf("%s idle_after", name), out_valid, 0);
    chk($sformatf("%s ready_after", name), in_ready, 1);
  endtask

  initial begin
    bq_t         exp;
    logic [1:0]  t;
    logic [63:0] v;
    logic        s;
    logic        p;
    int          st_at;
    int          st_len;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_count", out_count, 0);
    chk("rst out_error", out_error, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", in_ready, 1);

    // Directed encodings (upper bits of i32 values must be ignored).
    send(TYPE_I32, 64'hDEAD_BEEF_0009_8765, 1'b0, 1'b0);
    exp = '{8'hE5, 8'h8E, 8'h26};
    recv("u32_624485", exp, -1, 0);

    send(TYPE_I64, 64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b0);
    exp = '{8'hC0, 8'hBB, 8'h78};
    recv("s64_m123456", exp, -1, 0);

    send(TYPE_I32, 64'h1234_5678_FFFF_FFFF, 1'b1, 1'b0);
    exp = '{8'h7F};
    recv("s32_m1", exp, -1, 0);

    send(TYPE_I32, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);
    exp = '{8'h00};
    recv("u32_0", exp, -1, 0);

    send(TYPE_I64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    recv("u64_max", exp, -1, 0);

    // Backpressure: three stall cycles on byte 2.
    send(TYPE_I32, 64'd624485, 1'b0, 1'b0);
    exp = '{8'hE5, 8'h8E, 8'h26};
    recv("bp_624485", exp, 1, 3);

    // Rejected float request, then a normal request.
    send(TYPE_F32, 64'h3F80_0000, 1'b0, 1'b0);
    chk("err pulse", out_error, 1);
    chk("err no_byte", out_valid, 0);
    chk("err not_ready", in_ready, 0);
    @(negedge clk);
    chk("err pulse_end", out_error, 0);
    chk("err no_byte2", out_valid, 0);
    send(TYPE_I32, 64'd1, 1'b0, 1'b0);
    exp = '{8'h01};
    recv("after_err", exp, -1, 0);

    // Reset in the middle of an encoding.
    send(TYPE_I32, 64'd624485, 1'b0, 1'b0);
    chk("midrst byte1", out_data, 8'hE5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst out_last", out_last, 0);
    chk("midrst out_count", out_count, 0);
    chk("midrst out_error", out_error, 0);
    chk("midrst in_ready", in_ready, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst no_bytes", out_valid, 0);
    end
    chk("midrst ready", in_ready, 1);

`ifdef LEB128_PAD_EN
    send(TYPE_I32, 64'd3, 1'b0, 1'b1);
    exp = '{8'h83, 8'h80, 8'h80, 8'h80, 8'h00};
    recv("pad_u3", exp, -1, 0);
    send(TYPE_I32, 64'hFFFF_FFFE, 1'b1, 1'b1);
    exp = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    recv("pad_sm2", exp, -1, 0);
`endif

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 1) ? TYPE_I64 : TYPE_I32;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 1)) v = v >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) v = ~v;
      s = 1'($urandom_range(0, 1));
`ifdef LEB128_PAD_EN
      p = 1'($urandom_range(0, 1));
`else
      p = 1'b0;
`endif
      exp = encode(t, v, s, p);
      st_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp.size() - 1)) : -1;
      st_len = int'($urandom_range(1, 3));
      send(t, v, s, 1'b0 | p);
      recv($sformatf("rnd%0d", n), exp, st_at, st_len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
